dmac_cfg_regfile: RTL and testbench
===================================

Name: dmac_cfg_regfile

Overview:
Parametrised APB-slave configuration register file for the multi-channel DMAC, replacing the single 32-bit config register. It holds per-channel source address, destination address and byte length, and issues a one-cycle start pulse to each channel engine. It tracks per-channel busy/done status and rejects illegal accesses with PSLVERR. It sits between the APB fabric and the DMAC channel engines.

Parameters:
N_CH, 2, number of DMA channels (1..8)
ADDR_W, 12, APB address width
LEN_W, 16, byte-length field width (1..32)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
psel_i  in  1  APB select
penable_i  in  1  APB enable (ACCESS phase)
paddr_i  in  ADDR_W  APB byte address
pwrite_i  in  1  1=write, 0=read
pwdata_i  in  32  APB write data
pready_o  out  1  APB ready
prdata_o  out  32  APB read data
pslverr_o  out  1  APB error
src_addr_o  out  32*N_CH  per-channel source address, ch0 in bits [31:0]
dst_addr_o  out  32*N_CH  per-channel destination address
byte_len_o  out  LEN_W*N_CH  per-channel byte length
start_o  out  N_CH  one-cycle start pulse per channel
done_i  in  N_CH  one-cycle completion pulse from each channel engine

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk. All registers, busy, done, start_o, pslverr_o and prdata_o go to 0; pready_o = 0.
- Map: channel c at base c*0x20; offsets 0x00 SRC (RW), 0x04 DST (RW), 0x08 LEN (RW, bits [LEN_W-1:0], upper bits read 0), 0x0C CMD (WO, bit0 = start, reads 0), 0x10 STATUS (bit0 busy RO, bit1 done W1C). Decode uses paddr_i[ADDR_W-1:2]; paddr_i[1:0] is ignored.
- APB: zero wait states. pready_o = psel_i & penable_i, combinational. A write commits at the clock edge ending the ACCESS cycle. prdata_o and pslverr_o are valid only in ACCESS, and 0 otherwise.
- pslverr_o = 1 and the access has no effect when any of the following holds:
  - channel index >= N_CH;
  - offset is not in the map;
  - write to SRC, DST, LEN or CMD.start while the channel is busy;
  - write to STATUS offset 0x10 is legal (W1C); a read of CMD is legal and returns 0.
- Start: CMD write with bit0 = 1, not busy, LEN != 0:
  - start_o[c] = 1 for exactly the next cycle;
  - busy set on the same edge; done cleared on the same edge.
- Start with LEN == 0: no start pulse, busy stays 0, done set to 1, no error.
- CMD write with bit0 = 0: no effect, no error.
- done_i[c] while busy: busy cleared and done set on that edge. done_i[c] while not busy is ignored.
- done_i[c] and a STATUS W1C of done in the same cycle: set wins, done = 1.
- Address, data and length outputs are direct register outputs and do not change while busy. The engine samples them on start_o.
- Channels are fully independent; several channels may be busy concurrently.
- Reset mid-transfer: busy, done and all fields clear. A done_i pulse arriving later is ignored.

Optional Feature:
DMAC_CFG_IRQ_EN:
- Defined: adds port irq_o (out, N_CH) and offset 0x14 IRQ_EN (RW, bit0) per channel, reset 0. irq_o[c] = done[c] & irq_en[c], registered, so it asserts 1 cycle after done sets. It clears 1 cycle after the done W1C.
- Undefined: no irq_o port; offset 0x14 is unmapped and returns pslverr_o = 1.

Test Plan:
- Reset, then read all ch0/ch1 offsets -> prdata 0, pslverr 0, start_o = 0.
- Write ch1 SRC=0x1000_0000, DST=0x2000_0040, LEN=0x0100, then read back -> same values; LEN write of 0xFFFF_0100 reads 0x0000_0100 (LEN_W=16).
- ch0 LEN=0x40, CMD=1 -> start_o[0]=1 for one cycle, STATUS=0x1. SRC write -> pslverr=1, value unchanged. done_i[0] pulse -> STATUS=0x2. Write STATUS=0x2 -> STATUS=0x0.
- ch0 LEN=0, CMD=1 -> no start pulse, STATUS=0x2. Second CMD=1 while ch1 busy -> pslverr=1 and no ch1 start; ch0 unaffected.
- Read paddr=0x40 with N_CH=2 and write offset 0x18 -> pslverr=1, prdata=0, no state change. done_i[1] coincident with STATUS W1C -> done remains 1.
- With DMAC_CFG_IRQ_EN: IRQ_EN=1, complete ch1 -> irq_o[1] rises 1 cycle after done; W1C -> irq_o[1] falls 1 cycle later. Without it, read of 0x14 -> pslverr=1.

Source files
------------

// File: rtl/dmac_cfg_regfile.sv
// APB configuration register file for the multi-channel DMAC: per-channel SRC/DST/LEN/CMD/STATUS.
// Optional define DMAC_CFG_IRQ_EN adds a per-channel IRQ_EN register and the irq_o outputs.
module dmac_cfg_regfile #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic [ADDR_W-1:0]       paddr_i,
    input  logic                    pwrite_i,
    input  logic [31:0]             pwdata_i,
    output logic                    pready_o,
    output logic [31:0]             prdata_o,
    output logic                    pslverr_o,
    output logic [32*N_CH-1:0]      src_addr_o,
    output logic [32*N_CH-1:0]      dst_addr_o,
    output logic [LEN_W*N_CH-1:0]   byte_len_o,
    output logic [N_CH-1:0]         start_o,
    input  logic [N_CH-1:0]         done_i
`ifdef DMAC_CFG_IRQ_EN
    ,
    output logic [N_CH-1:0]         irq_o
`endif
);

    localparam logic [2:0] OFF_SRC    = 3'd0;
    localparam logic [2:0] OFF_DST    = 3'd1;
    localparam logic [2:0] OFF_LEN    = 3'd2;
    localparam logic [2:0] OFF_CMD    = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;
`ifdef DMAC_CFG_IRQ_EN
    localparam logic [2:0] OFF_IRQEN  = 3'd5;
`endif

    logic [N_CH-1:0][31:0]      src_q;
    logic [N_CH-1:0][31:0]      dst_q;
    logic [N_CH-1:0][LEN_W-1:0] len_q;
    logic [N_CH-1:0]            busy_q;
    logic [N_CH-1:0]            done_q;
    logic [N_CH-1:0]            start_q;
`ifdef DMAC_CFG_IRQ_EN
    logic [N_CH-1:0]            irq_en_q;
    logic [N_CH-1:0]            irq_q;
`endif

    logic        access;
    logic [31:0] ch_idx;
    logic [2:0]  off;
    logic        ch_ok;
    logic [N_CH-1:0] hit;
    logic        busy_sel;
    logic        err;
    logic        wr_ok;
    logic [31:0] rd_word;
    logic        unused_addr_lsb;

    // Each channel owns a 32-byte window; byte-lane bits are don't-care.
    assign access          = psel_i & penable_i;
    assign ch_idx          = 32'(paddr_i[ADDR_W-1:5]);
    assign off             = paddr_i[4:2];
    assign ch_ok           = ch_idx < 32'(N_CH);
    assign unused_addr_lsb = ^paddr_i[1:0];

    always_comb begin
        hit = '0;
        for (int c = 0; c < N_CH; c++) begin
            hit[c] = (ch_idx == 32'(c));
        end
    end

    assign busy_sel = |(hit & busy_q);

    // Anything that would disturb a running transfer is refused.
    always_comb begin
        err = 1'b0;
        if (!ch_ok) begin
            err = 1'b1;
        end else begin
            case (off)
                OFF_SRC, OFF_DST, OFF_LEN: err = pwrite_i & busy_sel;
                OFF_CMD:                   err = pwrite_i & pwdata_i[0] & busy_sel;
                OFF_STATUS:                err = 1'b0;
`ifdef DMAC_CFG_IRQ_EN
                OFF_IRQEN:                 err = 1'b0;
`endif
                default:                   err = 1'b1;
            endcase
        end
    end

    assign wr_ok = access & pwrite_i & ~err;

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (hit[c]) begin
                case (off)
                    OFF_SRC:    rd_word = src_q[c];
                    OFF_DST:    rd_word = dst_q[c];
                    OFF_LEN:    rd_word = 32'(len_q[c]);
                    OFF_STATUS: rd_word = {30'b0, done_q[c], busy_q[c]};
`ifdef DMAC_CFG_IRQ_EN
                    OFF_IRQEN:  rd_word = {31'b0, irq_en_q[c]};
`endif
                    default:    rd_word = '0;
                endcase
            end
        end
    end

    assign pready_o  = access;
    assign pslverr_o = access & err;
    assign prdata_o  = (access && !pwrite_i && !err) ? rd_word : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            busy_q   <= '0;
            done_q   <= '0;
            start_q  <= '0;
`ifdef DMAC_CFG_IRQ_EN
            irq_en_q <= '0;
            irq_q    <= '0;
`endif
        end else begin
            start_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                if (wr_ok && hit[c]) begin
                    case (off)
                        OFF_SRC: src_q[c] <= pwdata_i;
                        OFF_DST: dst_q[c] <= pwdata_i;
                        OFF_LEN: len_q[c] <= pwdata_i[LEN_W-1:0];
                        OFF_CMD: begin
                            // A zero-length transfer completes immediately without bothering the engine.
                            if (pwdata_i[0]) begin
                                if (len_q[c] != '0) begin
                                    start_q[c] <= 1'b1;
                                    busy_q[c]  <= 1'b1;
                                    done_q[c]  <= 1'b0;
                                end else begin
                                    done_q[c]  <= 1'b1;
                                end
                            end
                        end
                        OFF_STATUS: begin
                            if (pwdata_i[1]) begin
                                done_q[c] <= 1'b0;
                            end
                        end
`ifdef DMAC_CFG_IRQ_EN
                        OFF_IRQEN: irq_en_q[c] <= pwdata_i[0];
`endif
                        default: ;
                    endcase
                end
                // Placed after the register write so a completion beats a same-cycle W1C.
                if (busy_q[c] && done_i[c]) begin
                    busy_q[c] <= 1'b0;
                    done_q[c] <= 1'b1;
                end
            end
`ifdef DMAC_CFG_IRQ_EN
            irq_q <= done_q & irq_en_q;
`endif
        end
    end

    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign byte_len_o = len_q;
    assign start_o    = start_q;
`ifdef DMAC_CFG_IRQ_EN
    assign irq_o      = irq_q;
`endif

endmodule

// File: tb/tb_dmac_cfg_regfile.sv
// Bench for dmac_cfg_regfile: directed steps plus randomized APB traffic against a register-map model.
module tb_dmac_cfg_regfile;

    localparam int N_CH   = 2;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  psel;
    logic                  penable;
    logic [ADDR_W-1:0]     paddr;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic                  pready;
    logic [31:0]           prdata;
    logic                  pslverr;
    logic [32*N_CH-1:0]    src_addr;
    logic [32*N_CH-1:0]    dst_addr;
    logic [LEN_W*N_CH-1:0] byte_len;
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       done_in;
`ifdef DMAC_CFG_IRQ_EN
    logic [N_CH-1:0]       irq;
`endif

    dmac_cfg_regfile #(.N_CH(N_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .psel_i     (psel),
        .penable_i  (penable),
        .paddr_i    (paddr),
        .pwrite_i   (pwrite),
        .pwdata_i   (pwdata),
        .pready_o   (pready),
        .prdata_o   (prdata),
        .pslverr_o  (pslverr),
        .src_addr_o (src_addr),
        .dst_addr_o (dst_addr),
        .byte_len_o (byte_len),
        .start_o    (start),
        .done_i     (done_in)
`ifdef DMAC_CFG_IRQ_EN
        ,
        .irq_o      (irq)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0]      m_src   [N_CH];
    logic [31:0]      m_dst   [N_CH];
    logic [LEN_W-1:0] m_len   [N_CH];
    logic             m_busy  [N_CH];
    logic             m_done  [N_CH];
    logic             m_irqen [N_CH];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_src[c] = '0; m_dst[c] = '0; m_len[c] = '0;
            m_busy[c] = 1'b0; m_done[c] = 1'b0; m_irqen[c] = 1'b0;
        end
    endtask

    function automatic logic exp_err(input int ch, input int off, input logic wr, input logic [31:0] d);
        if (ch >= N_CH) return 1'b1;
        case (off)
            0, 1, 2: return wr && m_busy[ch];
            3:       return wr && d[0] && m_busy[ch];
            4:       return 1'b0;
            5: begin
`ifdef DMAC_CFG_IRQ_EN
                return 1'b0;
`else
                return 1'b1;
`endif
            end
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input int ch, input int off);
        if (ch >= N_CH) return 32'h0;
        case (off)
            0:       return m_src[ch];
            1:       return m_dst[ch];
            2:       return 32'(m_len[ch]);
            4:       return {30'b0, m_done[ch], m_busy[ch]};
            5:       return {31'b0, m_irqen[ch]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(input int ch, input int off);
        logic [31:0] a;
        a = 32'(ch * 32 + off * 4) + 32'($urandom_range(0, 3));
        return a[ADDR_W-1:0];
    endfunction

    // Called and returns at 1 time unit after a rising edge.
    task automatic apb(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic [N_CH-1:0] dmask, output logic [31:0] rdata,
                       output logic slverr, output logic [N_CH-1:0] start_seen);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
        @(negedge clk);
        check("setup_prdata", prdata, 32'h0);
        check("setup_pslverr", {31'b0, pslverr}, 32'h0);
        @(posedge clk); #1;
        penable = 1'b1; done_in = dmask;
        @(negedge clk);
        rdata = prdata; slverr = pslverr;
        check("access_pready", {31'b0, pready}, 32'h1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; done_in = '0;
        start_seen = start;
    endtask

    task automatic mwrite(input int ch, input int off, input logic [31:0] d, input logic [N_CH-1:0] dmask);
        logic e;
        logic [N_CH-1:0] exp_start;
        logic [N_CH-1:0] st;
        logic [31:0] rdv;
        logic se;
        logic pre_busy [N_CH];
        e = exp_err(ch, off, 1'b1, d);
        exp_start = '0;
        for (int c = 0; c < N_CH; c++) pre_busy[c] = m_busy[c];
        apb(1'b1, mk_addr(ch, off), d, dmask, rdv, se, st);
        check("wr_pslverr", {31'b0, se}, {31'b0, e});
        if (!e) begin
            case (off)
                0: m_src[ch] = d;
                1: m_dst[ch] = d;
                2: m_len[ch] = d[LEN_W-1:0];
                3: if (d[0]) begin
                       if (m_len[ch] != '0) begin
                           m_busy[ch] = 1'b1; m_done[ch] = 1'b0; exp_start[ch] = 1'b1;
                       end else begin
                           m_done[ch] = 1'b1;
                       end
                   end
                4: if (d[1]) m_done[ch] = 1'b0;
                5: m_irqen[ch] = d[0];
                default: ;
            endcase
        end
        for (int c = 0; c < N_CH; c++) begin
            if (dmask[c] && pre_busy[c]) begin
                m_busy[c] = 1'b0; m_done[c] = 1'b1;
            end
        end
        check("wr_start", 32'(st), 32'(exp_start));
    endtask

    task automatic mread(input int ch, input int off);
        logic e;
        logic [31:0] x;
        logic [31:0] rdv;
        logic se;
        logic [N_CH-1:0] st;
        e = exp_err(ch, off, 1'b0, 32'h0);
        x = e ? 32'h0 : exp_rd(ch, off);
        apb(1'b0, mk_addr(ch, off), 32'h0, '0, rdv, se, st);
        check("rd_pslverr", {31'b0, se}, {31'b0, e});
        check("rd_data", rdv, x);
        check("rd_start", 32'(st), 32'h0);
    endtask

    task automatic mdone(input logic [N_CH-1:0] mask);
        done_in = mask;
        @(posedge clk); #1;
        done_in = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (mask[c] && m_busy[c]) begin
                m_busy[c] = 1'b0; m_done[c] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < N_CH; c++) begin
            check("src_addr_o", src_addr[c*32 +: 32], m_src[c]);
            check("dst_addr_o", dst_addr[c*32 +: 32], m_dst[c]);
            check("byte_len_o", 32'(byte_len[c*LEN_W +: LEN_W]), 32'(m_len[c]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ch;
        int off;
        int op;
        logic [31:0] d;
        logic [N_CH-1:0] dm;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0;
        pwrite = 1'b0; pwdata = '0; done_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_start", 32'(start), 32'h0);
        check("reset_pready", {31'b0, pready}, 32'h0);
        check("reset_prdata", prdata, 32'h0);
        check("reset_pslverr", {31'b0, pslverr}, 32'h0);
        rst_n = 1'b1;
        check_outputs();
        for (int c = 0; c < 2; c++) begin
            for (int o = 0; o < 5; o++) mread(c, o);
        end

        mwrite(1, 0, 32'h1000_0000, '0);
        mwrite(1, 1, 32'h2000_0040, '0);
        mwrite(1, 2, 32'h0000_0100, '0);
        mread(1, 0); mread(1, 1); mread(1, 2);
        mwrite(1, 2, 32'hFFFF_0100, '0);
        mread(1, 2);
        check_outputs();

        mwrite(0, 2, 32'h40, '0);
        mwrite(0, 3, 32'h1, '0);
        @(posedge clk); #1;
        check("start_one_cycle", 32'(start), 32'h0);
        mread(0, 4);
        mwrite(0, 0, 32'hDEAD_BEEF, '0);
        mread(0, 0);
        mdone(2'b01);
        mread(0, 4);
        mwrite(0, 4, 32'h2, '0);
        mread(0, 4);

        mwrite(0, 2, 32'h0, '0);
        mwrite(0, 3, 32'h1, '0);
        mread(0, 4);
        mwrite(1, 3, 32'h1, '0);
        mwrite(1, 3, 32'h1, '0);
        mwrite(1, 3, 32'h0, '0);
        mread(0, 4); mread(1, 4);

        mread(2, 0);
        mwrite(0, 6, 32'hFFFF_FFFF, '0);
        check_outputs();
        mwrite(1, 4, 32'h2, 2'b10);
        mread(1, 4);

`ifdef DMAC_CFG_IRQ_EN
        mwrite(1, 4, 32'h2, '0);
        mwrite(1, 5, 32'h1, '0);
        mread(1, 5);
        mwrite(1, 3, 32'h1, '0);
        mdone(2'b10);
        check("irq_before", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("irq_rise", 32'(irq), 32'h2);
        mwrite(1, 4, 32'h2, '0);
        check("irq_hold", 32'(irq), 32'h2);
        @(posedge clk); #1;
        check("irq_fall", 32'(irq), 32'h0);
`else
        mread(1, 5);
        mwrite(1, 5, 32'h1, '0);
`endif

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 9));
            ch = ($urandom_range(0, 7) == 0) ? int'($urandom_range(N_CH, 127))
                                             : int'($urandom_range(0, N_CH - 1));
            off = int'($urandom_range(0, 7));
            if (op < 2) begin
                dm = N_CH'($urandom);
                mdone(dm);
            end else if (op < 6) begin
                d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                dm = ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '0;
                mwrite(ch, off, d, dm);
            end else begin
                mread(ch, off);
            end
        end
        check_outputs();

        mdone('1);
        mwrite(0, 2, 32'h20, '0);
        mwrite(0, 3, 32'h1, '0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        check("midreset_start", 32'(start), 32'h0);
        mdone(2'b01);
        mread(0, 4);
        mread(0, 2);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
